control_sequencer: RTL and testbench

Microcoded-style control FSM sitting directly upstream of the scratchpad register file. It fetches instructions through a memory handshake into IR, increments PC, decodes the IR fields the register file exports, and drives the register-file write decoder, the bus A/B read selects and the ALU/C-bus controls. It executes one instruction at a time: ALU ops, load, store, branch-always.

---
 rtl/control_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute sequencer that drives the scratchpad
// register-file selects, the ALU and C-bus controls, and the memory handshake.

// Structural invariants of the sequencer outputs, kept apart from the datapath logic.
module control_sequencer_checker (
    input logic       clk,
    input logic       rst,
    input logic [3:0] stateCode,
    input logic [3:0] decoderSel,
    input logic       memReq,
    input logic       memWe,
    input logic       illegal
);

    storeNeedsReq: assert property (@(posedge clk) disable iff (rst) memWe |-> memReq);
    decoderCodeValid: assert property (@(posedge clk) disable iff (rst) decoderSel < 4'd14);
    stateCodeValid: assert property (@(posedge clk) disable iff (rst) stateCode <= 4'd9);
    illegalOnlyInHalt: assert property (@(posedge clk) disable iff (rst) illegal |-> (stateCode == 4'd9));

endmodule

module control_sequencer #(
    parameter int DATAWIDTH_BUS_REG_IR        = 5,
    parameter int DATAWIDTH_BUS_REG_IR_OP     = 8,
    parameter int DATAWIDTH_DECODER_SELECTION = 4,
    parameter int DATAWIDTH_MUX_SELECTION     = 4
) (
    input  logic                                   uDataPath_CLOCK_50,
    input  logic                                   uDATAPATH_RESET_InHigh,
    input  logic [DATAWIDTH_BUS_REG_IR_OP-1:0]     Scratchpath_Reg_IR_OP,
    input  logic [DATAWIDTH_BUS_REG_IR-1:0]        Scratchpath_Reg_IR_RS1,
    input  logic [DATAWIDTH_BUS_REG_IR-1:0]        Scratchpath_Reg_IR_RS2,
    input  logic [DATAWIDTH_BUS_REG_IR-1:0]        Scratchpath_Reg_IR_RD,
    input  logic                                   Scratchpath_Reg_IR_IR13,
    input  logic                                   Mem_Ack,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] Selector_Decoder_Wire,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     Selector_MUX_A_Wire,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     Selector_MUX_B_Wire,
    output logic [3:0]                             ALU_Op,
    output logic [1:0]                             B_Src_Sel,
    output logic                                   C_Src_Sel,
    output logic                                   Mem_Req,
    output logic                                   Mem_WE,
    output logic                                   Illegal_Instr,
    output logic [3:0]                             State_Out
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        INC      = 4'd2,
        DECODE   = 4'd3,
        EXEC_ALU = 4'd4,
        MEM_ADDR = 4'd5,
        LD_REQ   = 4'd6,
        ST_REQ   = 4'd7,
        EXEC_BR  = 4'd8,
        HALT     = 4'd9
    } state_t;

    localparam int FIELD_HI = DATAWIDTH_BUS_REG_IR - 1;

    localparam logic [DATAWIDTH_MUX_SELECTION-1:0]     MUX_PC     = 4'd8;
    localparam logic [DATAWIDTH_MUX_SELECTION-1:0]     MUX_TEMP0  = 4'd9;
    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEC_NONE   = 4'd0;
    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEC_PC     = 4'd8;
    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEC_TEMP0  = 4'd9;
    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEC_IR     = 4'd13;

    localparam logic [3:0] ALU_ADD      = 4'd0;
    localparam logic [1:0] BSRC_BUSB    = 2'd0;
    localparam logic [1:0] BSRC_SIMM13  = 2'd1;
    localparam logic [1:0] BSRC_FOUR    = 2'd2;
    localparam logic [1:0] BSRC_DISP22  = 2'd3;

    state_t state_r;
    state_t nextState_s;

    logic [DATAWIDTH_DECODER_SELECTION-1:0] decoder_r;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     muxA_r;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     muxB_r;
    logic [3:0]                             aluOp_r;
    logic [1:0]                             bSrc_r;
    logic                                   cSrc_r;
    logic                                   memReq_r;
    logic                                   memWe_r;
    logic                                   ackGate_r;
    logic                                   illegal_r;

    logic [DATAWIDTH_DECODER_SELECTION-1:0] nDecoder_s;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     nMuxA_s;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     nMuxB_s;
    logic [3:0]                             nAluOp_s;
    logic [1:0]                             nBSrc_s;
    logic                                   nCSrc_s;
    logic                                   nMemReq_s;
    logic                                   nMemWe_s;
    logic                                   nAckGate_s;

    logic isBr_s;
    logic isAlu_s;
    logic isLd_s;
    logic isSt_s;
    logic fieldsOk_s;

    logic [DATAWIDTH_MUX_SELECTION-1:0]     rs1Code_s;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     rs2Code_s;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     rdMuxCode_s;
    logic [DATAWIDTH_DECODER_SELECTION-1:0] rdDecCode_s;

    assign rs1Code_s   = Scratchpath_Reg_IR_RS1[DATAWIDTH_MUX_SELECTION-1:0];
    assign rs2Code_s   = Scratchpath_Reg_IR_RS2[DATAWIDTH_MUX_SELECTION-1:0];
    assign rdMuxCode_s = Scratchpath_Reg_IR_RD[DATAWIDTH_MUX_SELECTION-1:0];
    assign rdDecCode_s = Scratchpath_Reg_IR_RD[DATAWIDTH_DECODER_SELECTION-1:0];

    // Instruction classification; only g0..g7 are legal operand registers.
    assign isBr_s     = (Scratchpath_Reg_IR_OP[7:6] == 2'b00);
    assign isAlu_s    = (Scratchpath_Reg_IR_OP[7:6] == 2'b10) && (Scratchpath_Reg_IR_OP[5:0] <= 6'd4);
    assign isLd_s     = (Scratchpath_Reg_IR_OP == 8'hC0);
    assign isSt_s     = (Scratchpath_Reg_IR_OP == 8'hC4);
    assign fieldsOk_s = ~|Scratchpath_Reg_IR_RS1[FIELD_HI:3]
                      & ~|Scratchpath_Reg_IR_RD[FIELD_HI:3]
                      & (Scratchpath_Reg_IR_IR13 | ~|Scratchpath_Reg_IR_RS2[FIELD_HI:3]);

    // Next-state selection.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE:     nextState_s = FETCH;
            FETCH:    nextState_s = Mem_Ack ? INC : FETCH;
            INC:      nextState_s = DECODE;
            DECODE: begin
                if (isBr_s) begin
                    nextState_s = EXEC_BR;
                end else if (isAlu_s && fieldsOk_s) begin
                    nextState_s = EXEC_ALU;
                end else if ((isLd_s || isSt_s) && fieldsOk_s) begin
                    nextState_s = MEM_ADDR;
                end else begin
                    nextState_s = HALT;
                end
            end
            EXEC_ALU: nextState_s = FETCH;
            MEM_ADDR: nextState_s = isLd_s ? LD_REQ : ST_REQ;
            LD_REQ:   nextState_s = Mem_Ack ? FETCH : LD_REQ;
            ST_REQ:   nextState_s = Mem_Ack ? FETCH : ST_REQ;
            EXEC_BR:  nextState_s = FETCH;
            HALT:     nextState_s = HALT;
            default:  nextState_s = IDLE;
        endcase
    end

    // Output values for the state being entered, so every control leaves a flop.
    always_comb begin
        nDecoder_s = DEC_NONE;
        nMuxA_s    = 4'd0;
        nMuxB_s    = 4'd0;
        nAluOp_s   = ALU_ADD;
        nBSrc_s    = BSRC_BUSB;
        nCSrc_s    = 1'b0;
        nMemReq_s  = 1'b0;
        nMemWe_s   = 1'b0;
        nAckGate_s = 1'b0;
        case (nextState_s)
            FETCH: begin
                nMuxA_s    = MUX_PC;
                nMemReq_s  = 1'b1;
                nCSrc_s    = 1'b1;
                nDecoder_s = DEC_IR;
                nAckGate_s = 1'b1;
            end
            INC: begin
                nMuxA_s    = MUX_PC;
                nBSrc_s    = BSRC_FOUR;
                nDecoder_s = DEC_PC;
            end
            EXEC_ALU: begin
                nMuxA_s    = rs1Code_s;
                nAluOp_s   = {1'b0, Scratchpath_Reg_IR_OP[2:0]};
                nDecoder_s = rdDecCode_s;
                if (Scratchpath_Reg_IR_IR13) begin
                    nBSrc_s = BSRC_SIMM13;
                end else begin
                    nMuxB_s = rs2Code_s;
                end
            end
            MEM_ADDR: begin
                nMuxA_s    = rs1Code_s;
                nDecoder_s = DEC_TEMP0;
                if (Scratchpath_Reg_IR_IR13) begin
                    nBSrc_s = BSRC_SIMM13;
                end else begin
                    nMuxB_s = rs2Code_s;
                end
            end
            LD_REQ: begin
                nMuxA_s    = MUX_TEMP0;
                nMemReq_s  = 1'b1;
                nCSrc_s    = 1'b1;
                nDecoder_s = rdDecCode_s;
                nAckGate_s = 1'b1;
            end
            ST_REQ: begin
                nMuxA_s   = MUX_TEMP0;
                nMuxB_s   = rdMuxCode_s;
                nMemReq_s = 1'b1;
                nMemWe_s  = 1'b1;
            end
            EXEC_BR: begin
                nMuxA_s    = MUX_PC;
                nBSrc_s    = BSRC_DISP22;
                nDecoder_s = DEC_PC;
            end
            IDLE, DECODE, HALT: begin
                nDecoder_s = DEC_NONE;
            end
            default: begin
                nDecoder_s = DEC_NONE;
            end
        endcase
    end

    // State and registered control outputs; reset returns everything to idle.
    always_ff @(posedge uDataPath_CLOCK_50) begin
        if (uDATAPATH_RESET_InHigh) begin
            state_r   <= IDLE;
            decoder_r <= DEC_NONE;
            muxA_r    <= 4'd0;
            muxB_r    <= 4'd0;
            aluOp_r   <= ALU_ADD;
            bSrc_r    <= BSRC_BUSB;
            cSrc_r    <= 1'b0;
            memReq_r  <= 1'b0;
            memWe_r   <= 1'b0;
            ackGate_r <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            decoder_r <= nDecoder_s;
            muxA_r    <= nMuxA_s;
            muxB_r    <= nMuxB_s;
            aluOp_r   <= nAluOp_s;
            bSrc_r    <= nBSrc_s;
            cSrc_r    <= nCSrc_s;
            memReq_r  <= nMemReq_s;
            memWe_r   <= nMemWe_s;
            ackGate_r <= nAckGate_s;
            illegal_r <= illegal_r | (nextState_s == HALT);
        end
    end

    // Reads only land in the Ack cycle; a reset in that cycle suppresses the write.
    assign Selector_Decoder_Wire = (ackGate_r && (!Mem_Ack || uDATAPATH_RESET_InHigh)) ? DEC_NONE : decoder_r;
    assign Selector_MUX_A_Wire   = muxA_r;
    assign Selector_MUX_B_Wire   = muxB_r;
    assign ALU_Op                = aluOp_r;
    assign B_Src_Sel             = bSrc_r;
    assign C_Src_Sel             = cSrc_r;
    assign Mem_Req               = memReq_r;
    assign Mem_WE                = memWe_r;
    assign Illegal_Instr         = illegal_r;
    assign State_Out             = state_r;

    control_sequencer_checker u_checker (
        .clk        (uDataPath_CLOCK_50),
        .rst        (uDATAPATH_RESET_InHigh),
        .stateCode  (State_Out),
        .decoderSel (Selector_Decoder_Wire),
        .memReq     (Mem_Req),
        .memWe      (Mem_WE),
        .illegal    (Illegal_Instr)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer: each record is one clock
// cycle of inputs plus the outputs expected during that cycle.
module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       ir13;
    logic       ack;
    logic [3:0] decSel;
    logic [3:0] muxA;
    logic [3:0] muxB;
    logic [3:0] aluOp;
    logic [1:0] bSrc;
    logic       cSrc;
    logic       memReq;
    logic       memWe;
    logic       illegal;
    logic [3:0] stateOut;

    int total;
    int bad;
    int cycleNo;

    typedef struct {
        logic       rst;
        logic       ack;
        logic [7:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       i13;
        logic [3:0] st;
        logic [3:0] dec;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] alu;
        logic [1:0] bs;
        logic       cs;
        logic       req;
        logic       we;
        logic       ill;
    } vec_t;

    vec_t tbl[$];

    control_sequencer dut (
        .uDataPath_CLOCK_50      (clk),
        .uDATAPATH_RESET_InHigh  (rst),
        .Scratchpath_Reg_IR_OP   (op),
        .Scratchpath_Reg_IR_RS1  (rs1),
        .Scratchpath_Reg_IR_RS2  (rs2),
        .Scratchpath_Reg_IR_RD   (rd),
        .Scratchpath_Reg_IR_IR13 (ir13),
        .Mem_Ack                 (ack),
        .Selector_Decoder_Wire   (decSel),
        .Selector_MUX_A_Wire     (muxA),
        .Selector_MUX_B_Wire     (muxB),
        .ALU_Op                  (aluOp),
        .B_Src_Sel               (bSrc),
        .C_Src_Sel               (cSrc),
        .Mem_Req                 (memReq),
        .Mem_WE                  (memWe),
        .Illegal_Instr           (illegal),
        .State_Out               (stateOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int r, int k, int o, int s1, int s2, int d, int im,
                                int st, int dec, int a, int b, int alu, int bs,
                                int cs, int req, int we, int ill);
        vec_t v;
        v.rst = r[0];   v.ack = k[0];   v.op = o[7:0];
        v.rs1 = s1[4:0]; v.rs2 = s2[4:0]; v.rd = d[4:0]; v.i13 = im[0];
        v.st = st[3:0]; v.dec = dec[3:0]; v.a = a[3:0]; v.b = b[3:0];
        v.alu = alu[3:0]; v.bs = bs[1:0]; v.cs = cs[0]; v.req = req[0];
        v.we = we[0]; v.ill = ill[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL cycle=%0d %s got=%0d expected=%0d", cycleNo, name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare on the falling edge, then cross the rising edge.
    task automatic applyVec(input vec_t v);
        rst  = v.rst;  ack = v.ack;  op = v.op;
        rs1  = v.rs1;  rs2 = v.rs2;  rd = v.rd;  ir13 = v.i13;
        @(negedge clk);
        check("state",   stateOut,         v.st);
        check("decoder", decSel,           v.dec);
        check("muxA",    muxA,             v.a);
        check("muxB",    muxB,             v.b);
        check("aluOp",   aluOp,            v.alu);
        check("bSrc",    {2'b00, bSrc},    {2'b00, v.bs});
        check("cSrc",    {3'b000, cSrc},   {3'b000, v.cs});
        check("memReq",  {3'b000, memReq}, {3'b000, v.req});
        check("memWe",   {3'b000, memWe},  {3'b000, v.we});
        check("illegal", {3'b000, illegal},{3'b000, v.ill});
        cycleNo++;
        @(posedge clk);
        #1;
    endtask

    // FETCH with zero-wait Ack, then INC and DECODE for the given instruction.
    task automatic fetchDecode(input int o, input int s1, input int s2, input int d, input int im);
        applyVec(mk(0,1,o,s1,s2,d,im, 1,13,8,0,0,0,1,1,0,0));
        applyVec(mk(0,0,o,s1,s2,d,im, 2, 8,8,0,0,2,0,0,0,0));
        applyVec(mk(0,0,o,s1,s2,d,im, 3, 0,0,0,0,0,0,0,0,0));
    endtask

    // Illegal instruction: HALT is sticky, ignores Ack, and only reset leaves it.
    task automatic haltSequence(input int o, input int s1, input int s2, input int d, input int im);
        fetchDecode(o, s1, s2, d, im);
        for (int i = 0; i < 12; i++) begin
            applyVec(mk(0,i%2,o,s1,s2,d,im, 9,0,0,0,0,0,0,0,0,1));
        end
        applyVec(mk(1,0,o,s1,s2,d,im, 9,0,0,0,0,0,0,0,0,1));
        applyVec(mk(0,0,o,s1,s2,d,im, 0,0,0,0,0,0,0,0,0,0));
    endtask

    initial begin
        total = 0; bad = 0; cycleNo = 0;
        rst = 1'b1; ack = 1'b0; op = 8'h00; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; ir13 = 1'b0;
        @(posedge clk);
        #1;

        // Reset held over three edges, then the IDLE cycle.
        tbl.push_back(mk(1,0,8'h80,1,2,3,0, 0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,8'h80,1,2,3,0, 0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h80,1,2,3,0, 0,0,0,0,0,0,0,0,0,0));
        // add r3,r1,r2
        tbl.push_back(mk(0,1,8'h80,1,2,3,0, 1,13,8,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,8'h80,1,2,3,0, 2, 8,8,0,0,2,0,0,0,0));
        tbl.push_back(mk(0,0,8'h80,1,2,3,0, 3, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h80,1,2,3,0, 4, 3,1,2,0,0,0,0,0,0));
        // ld r5,[r2+imm]: one fetch wait, two load waits
        tbl.push_back(mk(0,0,8'h80,1,2,3,0, 1, 0,8,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,1,8'hC0,2,0,5,1, 1,13,8,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,8'hC0,2,0,5,1, 2, 8,8,0,0,2,0,0,0,0));
        tbl.push_back(mk(0,0,8'hC0,2,0,5,1, 3, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'hC0,2,0,5,1, 5, 9,2,0,0,1,0,0,0,0));
        tbl.push_back(mk(0,0,8'hC0,2,0,5,1, 6, 0,9,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,8'hC0,2,0,5,1, 6, 0,9,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,1,8'hC0,2,0,5,1, 6, 5,9,0,0,0,1,1,0,0));
        // st r4,[r1+r6] with one store wait
        tbl.push_back(mk(0,1,8'hC4,1,6,4,0, 1,13,8,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,8'hC4,1,6,4,0, 2, 8,8,0,0,2,0,0,0,0));
        tbl.push_back(mk(0,0,8'hC4,1,6,4,0, 3, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'hC4,1,6,4,0, 5, 9,1,6,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'hC4,1,6,4,0, 7, 0,9,4,0,0,0,1,1,0));
        tbl.push_back(mk(0,1,8'hC4,1,6,4,0, 7, 0,9,4,0,0,0,1,1,0));
        // branch-always with junk register fields; stray Ack while Req=0
        tbl.push_back(mk(0,1,8'h00,31,31,31,0, 1,13,8,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,1,8'h00,31,31,31,0, 2, 8,8,0,0,2,0,0,0,0));
        tbl.push_back(mk(0,1,8'h00,31,31,31,0, 3, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,31,31,31,0, 8, 8,8,0,0,3,0,0,0,0));
        // xor r0,r7,imm: rs2 unused, rd=0 issues no write
        tbl.push_back(mk(0,1,8'h83,7,31,0,1, 1,13,8,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,8'h83,7,31,0,1, 2, 8,8,0,0,2,0,0,0,0));
        tbl.push_back(mk(0,0,8'h83,7,31,0,1, 3, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h83,7,31,0,1, 4, 0,7,0,3,1,0,0,0,0));
        tbl.push_back(mk(0,0,8'h83,7,31,0,1, 1, 0,8,0,0,0,1,1,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            applyVec(tbl[i]);
        end

        haltSequence(8'h80, 9, 0, 1, 0);
        haltSequence(8'h85, 1, 2, 3, 0);

        // Reset with Ack in an LD_REQ wait: no rd write, Req drops, clean refetch.
        fetchDecode(8'hC0, 2, 0, 5, 1);
        applyVec(mk(0,0,8'hC0,2,0,5,1, 5,9,2,0,0,1,0,0,0,0));
        applyVec(mk(0,0,8'hC0,2,0,5,1, 6,0,9,0,0,0,1,1,0,0));
        applyVec(mk(1,1,8'hC0,2,0,5,1, 6,0,9,0,0,0,1,1,0,0));
        applyVec(mk(0,0,8'hC0,2,0,5,1, 0,0,0,0,0,0,0,0,0,0));
        applyVec(mk(0,0,8'hC0,2,0,5,1, 1,0,8,0,0,0,1,1,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
